// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, decode helpers, default latencies, HI/LO payload.
// Optional multiply-accumulate decode is controlled by E_MDU_MADD_EN.
package mdu_pkg;

  localparam int unsigned OP_W            = 4;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd9;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Reads of HI/LO that feed the E-stage result path
  function automatic logic is_mf(input logic [OP_W-1:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  // Any op the hazard unit must hold in D while the MDU is busy
  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
`ifdef E_MDU_MADD_EN
    return (op >= OP_MULT) && (op <= OP_MADDU);
`else
    return (op >= OP_MULT) && (op <= OP_MFLO);
`endif
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU request/result bundle between the pipeline (master) and the MDU (slave).
interface e_mdu_if;
  import mdu_pkg::*;

  logic            start;
  logic [OP_W-1:0] mdu_op;
  logic [31:0]     src_a;
  logic [31:0]     src_b;
  logic            busy;
  logic [31:0]     hi;
  logic [31:0]     lo;
  logic [31:0]     mdu_out;

  modport master (
    output start, mdu_op, src_a, src_b,
    input  busy, hi, lo, mdu_out
  );

  modport slave (
    input  start, mdu_op, src_a, src_b,
    output busy, hi, lo, mdu_out
  );
endinterface

// File: rtl/mdu_div32.sv
// Combinational 32/32 signed/unsigned divider; quotient truncates toward zero,
// remainder follows the dividend sign, divide-by-zero is flagged and yields 0/0.
module mdu_div32 (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Magnitude divide, then restore signs; 0x80000000/-1 wraps back to 0x80000000
  always_comb begin
    neg_a     = is_signed & dividend[31];
    neg_b     = is_signed & divisor[31];
    mag_a     = neg_a ? (~dividend + 32'd1) : dividend;
    mag_b     = neg_b ? (~divisor + 32'd1) : divisor;
    div_zero  = (divisor == 32'd0);
    q_mag     = 32'd0;
    r_mag     = 32'd0;
    if (!div_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quotient  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    remainder = neg_a ? (~r_mag + 32'd1) : r_mag;
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with private HI/LO and a busy counter.
// Define E_MDU_MADD_EN to decode MADD/MADDU (64-bit accumulate into HI:LO).
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  e_mdu_if.slave     bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_t       state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [31:0]      hi_q, hi_nx;
  logic [31:0]      lo_q, lo_nx;
  hilo_t            pend_q, pend_nx;

  logic        mul_signed;
  logic        div_signed;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  // One shared 64x64 multiplier; sign-extension selects signed vs unsigned
  assign mul_signed = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MADD);
  assign div_signed = (bus.mdu_op == OP_DIV);
  assign prod = {{32{mul_signed & bus.src_a[31]}}, bus.src_a} *
                {{32{mul_signed & bus.src_b[31]}}, bus.src_b};

`ifdef E_MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q} + prod;
`endif

  mdu_div32 u_div (
    .dividend  (bus.src_a),
    .divisor   (bus.src_b),
    .is_signed (div_signed),
    .quotient  (quo),
    .remainder (rem),
    .div_zero  (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      hi_q   <= hi_nx;
      lo_q   <= lo_nx;
      pend_q <= pend_nx;
    end
  end

  // Accept only in IDLE; the result is captured at accept and committed on the 1->0 count edge
  always_comb begin
    state_nx = state;
    count_nx = count;
    hi_nx    = hi_q;
    lo_nx    = lo_q;
    pend_nx  = pend_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.mdu_op)
            OP_MULT, OP_MULTU: begin
              pend_nx  = hilo_t'(prod);
              count_nx = CNT_W'(MULT_CYCLES);
              state_nx = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_nx  = div_zero ? '{hi: hi_q, lo: lo_q} : '{hi: rem, lo: quo};
              count_nx = CNT_W'(DIV_CYCLES);
              state_nx = ST_RUN;
            end
`ifdef E_MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
              pend_nx  = hilo_t'(acc);
              count_nx = CNT_W'(MULT_CYCLES);
              state_nx = ST_RUN;
            end
`endif
            OP_MTHI: hi_nx = bus.src_a;
            OP_MTLO: lo_nx = bus.src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        count_nx = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          hi_nx    = pend_q.hi;
          lo_nx    = pend_q.lo;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.busy    = (state == ST_RUN);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mdu_out = !is_mf(bus.mdu_op)     ? 32'd0 :
                       (bus.mdu_op == OP_MFHI) ? hi_q  : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO/busy expectations.
module tb_e_mdu;
  import mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   nb;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op for a single edge, then count busy cycles (bounded)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.src_a  = a;
    bus.src_b  = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.mdu_op = OP_NONE;
    nbusy = 0;
    while (bus.busy && nbusy < 100) begin
      nbusy++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start  = 1'b0;
    bus.mdu_op = OP_NONE;
    bus.src_a  = '0;
    bus.src_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_out", bus.mdu_out, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, nb);
    chk("mult_busy", 32'(nb), 32'd5);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, nb);
    chk("multu_busy", 32'(nb), 32'd5);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_busy", 32'(nb), 32'd10);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op(OP_DIVU, 32'd7, 32'd0, nb);
    chk("divz_busy", 32'(nb), 32'd10);
    chk("divz_hi", bus.hi, 32'hFFFF_FFFF);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFD);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'd0);

    run_op(OP_DIVU, 32'd100, 32'd7, nb);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, nb);
    chk("divu_big_lo", bus.lo, 32'h0FFF_FFFF);
    chk("divu_big_hi", bus.hi, 32'h0000_000F);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nb);
    chk("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", bus.hi, 32'd1);

    // Move-to then move-from on the very next cycle
    run_op(OP_MTHI, 32'h1234_5678, 32'd0, nb);
    chk("mthi_busy", 32'(nb), 32'd0);
    chk("mthi_hi", bus.hi, 32'h1234_5678);
    bus.mdu_op = OP_MFHI;
    #1;
    chk("mfhi_out", bus.mdu_out, 32'h1234_5678);
    bus.mdu_op = OP_NONE;
    @(posedge clk); #1;
    run_op(OP_MTLO, 32'hCAFE_BABE, 32'd0, nb);
    chk("mtlo_busy", 32'(nb), 32'd0);
    bus.mdu_op = OP_MFLO;
    #1;
    chk("mflo_out", bus.mdu_out, 32'hCAFE_BABE);
    bus.mdu_op = OP_MULT;
    #1;
    chk("nonmf_out", bus.mdu_out, 32'd0);
    bus.mdu_op = OP_NONE;
    @(posedge clk); #1;

    // Start held high while busy: the second request must be ignored
    bus.start  = 1'b1;
    bus.mdu_op = OP_MULT;
    bus.src_a  = 32'd3;
    bus.src_b  = 32'd4;
    @(posedge clk); #1;
    bus.mdu_op = OP_MULTU;
    bus.src_a  = 32'd7;
    bus.src_b  = 32'd7;
    nb = 0;
    while (bus.busy && nb < 100) begin
      nb++;
      @(posedge clk); #1;
    end
    bus.start  = 1'b0;
    bus.mdu_op = OP_NONE;
    chk("hold_busy", 32'(nb), 32'd5);
    chk("hold_hi", bus.hi, 32'd0);
    chk("hold_lo", bus.lo, 32'd12);
    @(posedge clk); #1;

`ifdef E_MDU_MADD_EN
    run_op(OP_MTHI, 32'd0, 32'd0, nb);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, nb);
    run_op(OP_MADDU, 32'd1, 32'd1, nb);
    chk("maddu_busy", 32'(nb), 32'd5);
    chk("maddu_hi", bus.hi, 32'd1);
    chk("maddu_lo", bus.lo, 32'd0);
    run_op(OP_MTHI, 32'd0, 32'd0, nb);
    run_op(OP_MTLO, 32'd0, 32'd0, nb);
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd1, nb);
    chk("madd_hi", bus.hi, 32'hFFFF_FFFF);
    chk("madd_lo", bus.lo, 32'hFFFF_FFFF);
`else
    run_op(OP_MADD, 32'd5, 32'd5, nb);
    chk("op9_busy", 32'(nb), 32'd0);
    chk("op9_hi", bus.hi, 32'd0);
    chk("op9_lo", bus.lo, 32'd12);
`endif

    // Asynchronous reset during the third busy cycle of a divide
    bus.start  = 1'b1;
    bus.mdu_op = OP_DIVU;
    bus.src_a  = 32'd100;
    bus.src_b  = 32'd7;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.mdu_op = OP_NONE;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("postrst_busy", 32'(bus.busy), 32'd0);
    chk("postrst_hi", bus.hi, 32'd0);
    chk("postrst_lo", bus.lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
